alu_op_sequencer: RTL and testbench

- Upstream feeder for the 3-to-8 one-hot select decoder in the ALU library.
- Buffers incoming 3-bit ALU opcodes in a small FIFO and issues them one at a time on registered A/B/C select lines. The decoder turns these into the one-hot operation select.
- Holds each opcode stable for a per-opcode number of cycles: single-cycle ops vs. multi-cycle ops (e.g. shifts).
- Provides a ready/valid push interface upstream and a valid/done indication downstream.

---
 rtl/alu_op_sequencer.sv | 103 ++++++++++
 tb/tb_alu_op_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU opcode sequencer: buffers 3-bit opcodes in a small FIFO and issues them on
// registered A/B/C select lines, holding each for a per-opcode number of cycles.
module alu_op_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MULTI_CYCLES = 3,
  parameter logic [7:0]  MULTI_MASK   = 8'hC0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2:0]               OP_IN,
  input  logic                     OP_VALID,
  output logic                     OP_READY,
  input  logic                     ISSUE_EN,
  output logic                     A,
  output logic                     B,
  output logic                     C,
  output logic                     SEL_VALID,
  output logic                     OP_DONE,
  output logic [$clog2(DEPTH):0]   FIFO_CNT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [3:0]  RemMulti = 4'(MULTI_CYCLES - 1);

  logic [2:0]      r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;

  logic [2:0]      r_abc;
  logic            r_sel_valid;
  logic [3:0]      r_rem;

  logic            w_not_full;
  logic            w_not_empty;
  logic            w_push;
  logic            w_load;
  logic [2:0]      w_head;
  logic            w_head_multi;

  assign w_not_full   = (r_cnt < CntW'(DEPTH));
  assign w_not_empty  = (r_cnt != '0);
  assign OP_READY     = w_not_full && !RST;
  assign w_push       = OP_VALID && OP_READY;
  // A slot is free when idle or in the final cycle of its hold count.
  assign w_load       = w_not_empty && ISSUE_EN && (!r_sel_valid || (r_rem == '0));
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_multi = MULTI_MASK[w_head];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= OP_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_load})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_abc       <= '0;
      r_sel_valid <= 1'b0;
      r_rem       <= '0;
    end else if (w_load) begin
      r_abc       <= w_head;
      r_sel_valid <= 1'b1;
      r_rem       <= w_head_multi ? RemMulti : 4'd0;
    end else if (r_sel_valid) begin
      if (r_rem != '0) begin
        r_rem <= r_rem - 1'b1;
      end else begin
        // A/B/C keep their last value; the decoder ignores them while idle.
        r_sel_valid <= 1'b0;
      end
    end
  end

  assign A         = r_abc[2];
  assign B         = r_abc[1];
  assign C         = r_abc[0];
  assign SEL_VALID = r_sel_valid;
  assign OP_DONE   = r_sel_valid && (r_rem == '0);
  assign FIFO_CNT  = r_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations, then random traffic.
module tb_alu_op_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MULTI_CYCLES = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] OP_IN = 3'd0;
  logic       OP_VALID = 1'b0;
  logic       ISSUE_EN = 1'b0;
  logic       OP_READY, A, B, C, SEL_VALID, OP_DONE;
  logic [2:0] FIFO_CNT;

  alu_op_sequencer #(
    .DEPTH(DEPTH),
    .MULTI_CYCLES(MULTI_CYCLES),
    .MULTI_MASK(8'hC0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .OP_IN(OP_IN),
    .OP_VALID(OP_VALID),
    .OP_READY(OP_READY),
    .ISSUE_EN(ISSUE_EN),
    .A(A),
    .B(B),
    .C(C),
    .SEL_VALID(SEL_VALID),
    .OP_DONE(OP_DONE),
    .FIFO_CNT(FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending opcodes plus the opcode in the slot and the
  // number of cycles it still has to be held after the current one.
  logic [2:0] m_q[$];
  logic [2:0] m_abc = 3'd0;
  bit         m_sv = 1'b0;
  int         m_left = 0;
  bit         m_init = 1'b0;
  logic [7:0] m_mask = 8'hC0;
  bit         m_push, m_load;
  logic [2:0] m_head;

  always @(posedge CLK) begin
    if (RST) begin
      m_q.delete();
      m_abc  = 3'd0;
      m_sv   = 1'b0;
      m_left = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      m_push = OP_VALID && (m_q.size() < DEPTH);
      m_load = (m_q.size() > 0) && ISSUE_EN && (!m_sv || m_left == 0);
      if (m_load) begin
        m_head = m_q.pop_front();
        m_abc  = m_head;
        m_sv   = 1'b1;
        m_left = m_mask[m_head] ? MULTI_CYCLES - 1 : 0;
      end else if (m_sv) begin
        if (m_left > 0) m_left--;
        else m_sv = 1'b0;
      end
      if (m_push) m_q.push_back(OP_IN);
    end
  end

  always @(negedge CLK) begin
    if (m_init) begin
      chk("A", 32'(A), 32'(m_abc[2]));
      chk("B", 32'(B), 32'(m_abc[1]));
      chk("C", 32'(C), 32'(m_abc[0]));
      chk("SEL_VALID", 32'(SEL_VALID), 32'(m_sv));
      chk("OP_DONE", 32'(OP_DONE), 32'(m_sv && m_left == 0));
      chk("FIFO_CNT", 32'(FIFO_CNT), 32'(m_q.size()));
      chk("OP_READY", 32'(OP_READY), 32'((m_q.size() < DEPTH) && !RST));
    end
  end

  // Drive inputs for one edge, then return 1 time unit after that edge.
  task automatic step(input logic v, input logic [2:0] op, input logic ie, input logic rst);
    OP_VALID = v;
    OP_IN    = op;
    ISSUE_EN = ie;
    RST      = rst;
    @(posedge CLK);
    #1;
  endtask

  logic [4:0] trace[$];  // {OP_DONE, SEL_VALID, A, B, C} per sampled cycle
  logic [2:0] ops[$];
  bit         dns[$];
  bit         gap;

  task automatic sample();
    trace.push_back({OP_DONE, SEL_VALID, A, B, C});
  endtask

  task automatic analyse();
    int first;
    int last;
    first = -1;
    last = -1;
    ops.delete();
    dns.delete();
    gap = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i][3]) begin
        if (first < 0) first = i;
        last = i;
        ops.push_back(trace[i][2:0]);
        dns.push_back(trace[i][4]);
      end
    end
    if (first >= 0 && (last - first + 1) != ops.size()) gap = 1'b1;
    trace.delete();
  endtask

  logic [2:0] exp_ops[$];
  int         n_done;

  initial begin
    // Reset then idle
    step(1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    chk("rst_abc", 32'({A, B, C}), 32'd0);
    chk("rst_sel_valid", 32'(SEL_VALID), 32'd0);
    chk("rst_op_done", 32'(OP_DONE), 32'd0);
    chk("rst_fifo_cnt", 32'(FIFO_CNT), 32'd0);
    chk("rst_op_ready_low", 32'(OP_READY), 32'd0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("op_ready_after_rst", 32'(OP_READY), 32'd1);

    // Single op latency
    step(1'b1, 3'b011, 1'b1, 1'b0);
    chk("single_n_sel_valid", 32'(SEL_VALID), 32'd0);
    chk("single_n_cnt", 32'(FIFO_CNT), 32'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("single_abc", 32'({A, B, C}), 32'b011);
    chk("single_sel_valid", 32'(SEL_VALID), 32'd1);
    chk("single_done", 32'(OP_DONE), 32'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("single_idle", 32'(SEL_VALID), 32'd0);

    // Multi-cycle hold
    trace.delete();
    step(1'b1, 3'b110, 1'b1, 1'b0);
    sample();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b0);
      sample();
    end
    analyse();
    chk("multi_len", 32'(ops.size()), 32'd3);
    chk("multi_gap", 32'(gap), 32'd0);
    if (ops.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("multi_abc", 32'(ops[i]), 32'b110);
        chk("multi_done", 32'(dns[i]), (i == 2) ? 32'd1 : 32'd0);
      end
    end

    // Back-to-back mix
    step(1'b1, 3'd1, 1'b1, 1'b0);
    sample();
    step(1'b1, 3'd7, 1'b1, 1'b0);
    sample();
    step(1'b1, 3'd2, 1'b1, 1'b0);
    sample();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b0);
      sample();
    end
    analyse();
    exp_ops = '{3'd1, 3'd7, 3'd7, 3'd7, 3'd2};
    chk("b2b_len", 32'(ops.size()), 32'd5);
    chk("b2b_gap", 32'(gap), 32'd0);
    n_done = 0;
    foreach (dns[i]) if (dns[i]) n_done++;
    chk("b2b_done_pulses", 32'(n_done), 32'd3);
    if (ops.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("b2b_op", 32'(ops[i]), 32'(exp_ops[i]));
    end

    // Full FIFO, fifth push dropped
    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i), 1'b0, 1'b0);
    chk("full_cnt", 32'(FIFO_CNT), 32'd4);
    chk("full_ready", 32'(OP_READY), 32'd0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    chk("full_drop_cnt", 32'(FIFO_CNT), 32'd4);
    chk("full_no_issue", 32'(SEL_VALID), 32'd0);
    trace.delete();
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("full_ready_after_pop", 32'(OP_READY), 32'd1);
    chk("full_cnt_after_pop", 32'(FIFO_CNT), 32'd3);
    sample();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b0);
      sample();
    end
    analyse();
    chk("full_issued", 32'(ops.size()), 32'd4);
    chk("full_gap", 32'(gap), 32'd0);
    if (ops.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("full_order", 32'(ops[i]), 32'(i + 1));
    end

    // Reset mid-op: cycle 2 of opcode 7 with two entries queued
    step(1'b1, 3'd7, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    chk("midrst_pre_abc", 32'({A, B, C}), 32'd7);
    chk("midrst_pre_done", 32'(OP_DONE), 32'd0);
    chk("midrst_pre_cnt", 32'(FIFO_CNT), 32'd2);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    chk("midrst_sel_valid", 32'(SEL_VALID), 32'd0);
    chk("midrst_cnt", 32'(FIFO_CNT), 32'd0);
    chk("midrst_done", 32'(OP_DONE), 32'd0);
    trace.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b0);
      sample();
    end
    analyse();
    chk("midrst_no_issue", 32'(ops.size()), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
